mx_attn_loader: RTL

MX_ATTN_LOADER -- requirements
Module: mx_attn_loader

---
 rtl/mx_attn_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mx_attn_loader.sv
// mx_attn_loader
//   Collects one attention tile (Q, K^T, V plus their MX shared scales) from a
//   stream of MX blocks and holds it for a downstream consumer.
//   The blocks arrive in a fixed order: all Q blocks row-major, then K row-major
//   (stored transposed as K^T), then V row-major. Each block carries k signed
//   elements and one shared scale.
//
// Handshake: a beat is transferred on a rising i_clk edge when i_valid and
//   o_ready are both 1. o_ready is high in the three load phases and low in
//   HOLD and during reset. o_tile_valid is high exactly while in HOLD. The
//   consumer releases the tile with i_tile_ack, which only has an effect in HOLD.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid, o_ready     input block handshake
//   i_data               k elements, element e at [e*bit_width +: bit_width]
//   i_scale              shared scale of the block
//   o_tile_valid         complete tile held in the output arrays
//   i_tile_ack           consumer releases the tile
//   o_state              FSM state: 0 LOAD_Q, 1 LOAD_K, 2 LOAD_V, 3 HOLD
//   Q_o, Kt_o, V_o       element arrays
//   S_Q_o, S_Kt_o, S_V_o shared-scale arrays
module mx_attn_loader #(
    parameter int S_q         = 4,
    parameter int S_kv        = 4,
    parameter int d_kq        = 8,
    parameter int d_v         = 8,
    parameter int k           = 2,
    parameter int bit_width   = 8,
    parameter int scale_width = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [k*bit_width-1:0]        i_data,
    input  logic [scale_width-1:0]        i_scale,
    output logic                          o_tile_valid,
    input  logic                          i_tile_ack,
    output logic [1:0]                    o_state,
    output logic signed [bit_width-1:0]   Q_o    [S_q][d_kq],
    output logic signed [bit_width-1:0]   Kt_o   [d_kq][S_kv],
    output logic signed [bit_width-1:0]   V_o    [S_kv][d_v],
    output logic [scale_width-1:0]        S_Q_o  [S_q][d_kq/k],
    output logic [scale_width-1:0]        S_Kt_o [d_kq/k][S_kv],
    output logic [scale_width-1:0]        S_V_o  [S_kv][d_v/k]
);

    generate
        if ((d_kq % k) != 0 || (d_v % k) != 0) begin : g_bad_block_size
            $error("mx_attn_loader: d_kq and d_v must be multiples of k");
        end
    endgenerate

    localparam int BQ   = d_kq / k;   // blocks per Q/K row
    localparam int BV   = d_v / k;    // blocks per V row
    localparam int NQ   = S_q * BQ;
    localparam int NK   = S_kv * BQ;
    localparam int NV   = S_kv * BV;
    localparam int NMAX = (NQ > NK) ? ((NQ > NV) ? NQ : NV) : ((NK > NV) ? NK : NV);
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic [1:0] {
        LOAD_Q = 2'd0,
        LOAD_K = 2'd1,
        LOAD_V = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    int              w_beat;
    int              w_phase_len;
    logic            w_last;
    logic            w_acc;

    assign o_ready      = i_rst_n && (r_state != HOLD);
    assign o_tile_valid = (r_state == HOLD);
    assign o_state      = r_state;
    assign w_acc        = i_valid && o_ready;

    always_comb begin
        w_beat      = int'(r_cnt);
        w_phase_len = NQ;
        case (r_state)
            LOAD_K:  w_phase_len = NK;
            LOAD_V:  w_phase_len = NV;
            default: w_phase_len = NQ;
        endcase
        w_last = (w_beat == w_phase_len - 1);
    end

    // Next-state: the last accepted beat of a phase advances the phase on the
    // same edge and clears the shared beat counter.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            LOAD_Q, LOAD_K, LOAD_V: begin
                if (w_acc) begin
                    if (w_last) begin
                        w_cnt_next = '0;
                        case (r_state)
                            LOAD_Q:  w_state_next = LOAD_K;
                            LOAD_K:  w_state_next = LOAD_V;
                            default: w_state_next = HOLD;
                        endcase
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (i_tile_ack) begin
                    w_state_next = LOAD_Q;
                    w_cnt_next   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LOAD_Q;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Tile storage: the beat counter selects one block slot per phase. K rows
    // arrive un-transposed, so block c of K row j lands in column j of K^T.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < S_q; r++) begin
                for (int x = 0; x < d_kq; x++) Q_o[r][x] <= '0;
                for (int c = 0; c < BQ; c++)   S_Q_o[r][c] <= '0;
            end
            for (int j = 0; j < S_kv; j++) begin
                for (int x = 0; x < d_kq; x++) Kt_o[x][j] <= '0;
                for (int c = 0; c < BQ; c++)   S_Kt_o[c][j] <= '0;
                for (int x = 0; x < d_v; x++)  V_o[j][x] <= '0;
                for (int c = 0; c < BV; c++)   S_V_o[j][c] <= '0;
            end
        end else if (w_acc) begin
            case (r_state)
                LOAD_Q: begin
                    for (int r = 0; r < S_q; r++) begin
                        for (int c = 0; c < BQ; c++) begin
                            if (w_beat == r * BQ + c) begin
                                S_Q_o[r][c] <= i_scale;
                                for (int e = 0; e < k; e++)
                                    Q_o[r][c*k+e] <= i_data[e*bit_width +: bit_width];
                            end
                        end
                    end
                end
                LOAD_K: begin
                    for (int j = 0; j < S_kv; j++) begin
                        for (int c = 0; c < BQ; c++) begin
                            if (w_beat == j * BQ + c) begin
                                S_Kt_o[c][j] <= i_scale;
                                for (int e = 0; e < k; e++)
                                    Kt_o[c*k+e][j] <= i_data[e*bit_width +: bit_width];
                            end
                        end
                    end
                end
                LOAD_V: begin
                    for (int r = 0; r < S_kv; r++) begin
                        for (int c = 0; c < BV; c++) begin
                            if (w_beat == r * BV + c) begin
                                S_V_o[r][c] <= i_scale;
                                for (int e = 0; e < k; e++)
                                    V_o[r][c*k+e] <= i_data[e*bit_width +: bit_width];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
